// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window sequencer.
// Holds the sequencer state encoding and the counter width function.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WINDOW,
        DONE
    } seq_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter used for the pixel column and row positions.
// Counts inc pulses from 0 to max-1 and flags the wrapping increment.
module wrap_counter #(
    parameter int max   = 8,
    parameter int width = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [width-1:0] value,
    output logic             wrap
);

    assign wrap = inc && (value == width'(max - 1));

    // count position, returning to zero on wrap or clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear || wrap) begin
            value <= '0;
        end else if (inc) begin
            value <= value + width'(1);
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Streams a raster image into the line buffer and flags each
// cycle in which the buffer holds a complete KxK output window.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int image_width  = 8,
    parameter int image_height = 8,
    parameter int kernel_size  = 3,
    parameter int stride       = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 pixel_valid,
    output logic                                 pixel_ready,
    output logic                                 shift_en,
    output logic                                 window_valid,
    input  logic                                 window_ready,
    output logic [cnt_width(image_height)-1:0]   out_row,
    output logic [cnt_width(image_width)-1:0]    out_col,
    output logic                                 busy,
    output logic                                 done
);

    localparam int cw = cnt_width(image_width);
    localparam int rw = cnt_width(image_height);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [cw-1:0]   col;
    logic [rw-1:0]   row;
    logic            col_wrap;
    logic            last_acc;
    logic            clear_cnt;
    logic            load_win;
    logic            last_pend;
    logic            is_win;
    logic [rw-1:0]   win_row;
    logic [cw-1:0]   win_col;
    int              r_off;
    int              c_off;

    assign pixel_ready = (state == STREAM)
        || ((state == WINDOW) && window_ready);
    assign shift_en = pixel_valid && pixel_ready;

    wrap_counter #(
        .max   (image_width),
        .width (cw)
    ) u_col (
        .clock (clock),
        .reset (reset),
        .inc   (shift_en),
        .clear (clear_cnt),
        .value (col),
        .wrap  (col_wrap)
    );

    // row advances on column wrap; its wrap marks the frame's last pixel
    wrap_counter #(
        .max   (image_height),
        .width (rw)
    ) u_row (
        .clock (clock),
        .reset (reset),
        .inc   (col_wrap),
        .clear (clear_cnt),
        .value (row),
        .wrap  (last_acc)
    );

    // classify the pixel at the current position as a window corner
    always_comb begin
        r_off   = int'(row) - (kernel_size - 1);
        c_off   = int'(col) - (kernel_size - 1);
        is_win  = (r_off >= 0) && (c_off >= 0)
            && (r_off % stride == 0)
            && (c_off % stride == 0);
        win_row = rw'(r_off / stride);
        win_col = cw'(c_off / stride);
    end

    // next-state selection and counter/window control
    always_comb begin
        state_nxt = state;
        load_win  = 1'b0;
        clear_cnt = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    clear_cnt = 1'b1;
                end
            end
            STREAM: begin
                if (shift_en) begin
                    if (is_win) begin
                        state_nxt = WINDOW;
                        load_win  = 1'b1;
                    end else if (last_acc) begin
                        state_nxt = DONE;
                    end
                end
            end
            WINDOW: begin
                if (window_ready) begin
                    if (last_pend) begin
                        state_nxt = DONE;
                    end else if (shift_en && is_win) begin
                        load_win = 1'b1;
                    end else if (shift_en && last_acc) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // registered status outputs and latched window coordinates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            last_pend    <= 1'b0;
        end else begin
            window_valid <= (state_nxt == WINDOW);
            busy         <= (state_nxt == STREAM)
                || (state_nxt == WINDOW);
            done         <= (state_nxt == DONE);
            if (load_win) begin
                out_row   <= win_row;
                out_col   <= win_col;
                last_pend <= last_acc;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer.
// Three instances cover stride 1, 2 and 3 geometries.
module tb_conv_window_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic       pixel_valid;
    logic       window_ready;

    logic       pr   [3];
    logic       se   [3];
    logic       wv   [3];
    logic       bz   [3];
    logic       dn   [3];
    logic [1:0] orow0, ocol0;
    logic [2:0] orow1, ocol1;
    logic [2:0] orow2, ocol2;

    int sel;
    logic pr_s, se_s, wv_s, busy_s, dn_s;
    int orow_s, ocol_s;

    int errors = 0;
    int checks = 0;

    // model state
    int  mw, mh, mk, ms;
    bit  m_busy, m_pend, m_done, m_last;
    int  m_idx;
    int  m_orow [3];
    int  m_ocol [3];
    bit  exp_pr;

    int acc_cnt;
    int done_cnt;
    int stall_cnt;
    int wq_idx[$];
    int wq_r[$];
    int wq_c[$];

    conv_window_sequencer #(
        .image_width(4), .image_height(4),
        .kernel_size(3), .stride(1)
    ) u0 (
        .clock(clock), .reset(reset), .start(start[0]),
        .pixel_valid(pixel_valid), .pixel_ready(pr[0]),
        .shift_en(se[0]), .window_valid(wv[0]),
        .window_ready(window_ready),
        .out_row(orow0), .out_col(ocol0),
        .busy(bz[0]), .done(dn[0])
    );

    conv_window_sequencer #(
        .image_width(6), .image_height(6),
        .kernel_size(3), .stride(3)
    ) u1 (
        .clock(clock), .reset(reset), .start(start[1]),
        .pixel_valid(pixel_valid), .pixel_ready(pr[1]),
        .shift_en(se[1]), .window_valid(wv[1]),
        .window_ready(window_ready),
        .out_row(orow1), .out_col(ocol1),
        .busy(bz[1]), .done(dn[1])
    );

    conv_window_sequencer #(
        .image_width(6), .image_height(6),
        .kernel_size(3), .stride(2)
    ) u2 (
        .clock(clock), .reset(reset), .start(start[2]),
        .pixel_valid(pixel_valid), .pixel_ready(pr[2]),
        .shift_en(se[2]), .window_valid(wv[2]),
        .window_ready(window_ready),
        .out_row(orow2), .out_col(ocol2),
        .busy(bz[2]), .done(dn[2])
    );

    always #5 clock = ~clock;

    // route the selected instance to common observation signals
    always_comb begin
        pr_s   = pr[sel];
        se_s   = se[sel];
        wv_s   = wv[sel];
        busy_s = bz[sel];
        dn_s   = dn[sel];
        orow_s = (sel == 0) ? int'(orow0)
               : (sel == 1) ? int'(orow1) : int'(orow2);
        ocol_s = (sel == 0) ? int'(ocol0)
               : (sel == 1) ? int'(ocol1) : int'(ocol2);
    end

    task automatic chk(input string name, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pixel_ready"}, pr_s, 0);
        chk({tag, "_shift_en"}, se_s, 0);
        chk({tag, "_window_valid"}, wv_s, 0);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_done"}, dn_s, 0);
        chk({tag, "_out_row"}, orow_s, 0);
        chk({tag, "_out_col"}, ocol_s, 0);
    endtask

    function automatic bit is_window(input int r, input int c);
        return (r >= mk - 1) && (c >= mk - 1)
            && ((r - mk + 1) % ms == 0)
            && ((c - mk + 1) % ms == 0);
    endfunction

    // per-cycle comparison against the frame-level model
    always @(negedge clock) begin
        if (!reset) begin
            m_busy = 0; m_pend = 0; m_done = 0;
            m_last = 0; m_idx = 0;
            for (int i = 0; i < 3; i++) begin
                m_orow[i] = 0;
                m_ocol[i] = 0;
            end
            chk_reset_outs("in_reset");
        end else begin
            bit acc, cons, nd;
            int r, c;
            exp_pr = m_busy && (!m_pend || window_ready);
            chk("pixel_ready", pr_s, int'(exp_pr));
            chk("shift_en", se_s, int'(exp_pr && pixel_valid));
            chk("window_valid", wv_s, int'(m_pend));
            chk("busy", busy_s, int'(m_busy));
            chk("done", dn_s, int'(m_done));
            chk("out_row", orow_s, m_orow[sel]);
            chk("out_col", ocol_s, m_ocol[sel]);
            if (wv_s && window_ready) begin
                wq_idx.push_back(acc_cnt - 1);
                wq_r.push_back(orow_s);
                wq_c.push_back(ocol_s);
            end
            if (busy_s && pixel_valid && !pr_s) stall_cnt++;
            if (dn_s) done_cnt++;
            if (se_s) acc_cnt++;

            acc = exp_pr && pixel_valid;
            nd = 0;
            if (m_done) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (start[sel]) begin
                    m_busy = 1;
                    m_idx = 0;
                end
            end else begin
                cons = m_pend && window_ready;
                if (cons && m_last) begin
                    m_pend = 0; m_busy = 0; nd = 1;
                end else begin
                    if (cons) m_pend = 0;
                    if (acc) begin
                        r = m_idx / mw;
                        c = m_idx % mw;
                        if (is_window(r, c)) begin
                            m_pend = 1;
                            m_orow[sel] = (r - mk + 1) / ms;
                            m_ocol[sel] = (c - mk + 1) / ms;
                            m_last = (m_idx == mw * mh - 1);
                        end else if (m_idx == mw * mh - 1) begin
                            m_busy = 0; nd = 1;
                        end
                        m_idx++;
                    end
                end
            end
            m_done = nd;
        end
    end

    task automatic run_frame(input int s, input bit stall,
                             input bit mid_start,
                             input int abort_at);
        int budget;
        bit stalled;
        @(posedge clock); #1;
        sel = s;
        mw = (s == 0) ? 4 : 6;
        mh = mw;
        mk = 3;
        ms = (s == 0) ? 1 : (s == 1) ? 3 : 2;
        wq_idx.delete(); wq_r.delete(); wq_c.delete();
        done_cnt = 0; stall_cnt = 0; acc_cnt = 0;
        start[s] = 1'b1;
        @(posedge clock); #1;
        start[s] = 1'b0;
        window_ready = 1'b1;
        budget = 0;
        stalled = 0;
        while (!dn_s && budget < 500) begin
            pixel_valid = (acc_cnt < mw * mh);
            start[s] = mid_start && (acc_cnt == 5);
            if (abort_at > 0 && acc_cnt == abort_at) begin
                reset = 1'b0;
                #1;
                chk_reset_outs("abort");
                pixel_valid = 1'b0;
                repeat (2) @(posedge clock);
                #1 reset = 1'b1;
                return;
            end
            if (stall && !stalled && wv_s) begin
                stalled = 1;
                window_ready = 1'b0;
                repeat (3) begin
                    #1;
                    chk("stall_ready", pr_s, 0);
                    chk("stall_shift", se_s, 0);
                    chk("stall_row", orow_s, 0);
                    chk("stall_col", ocol_s, 0);
                    @(posedge clock); #1;
                end
                window_ready = 1'b1;
                #1;
                chk("resume_shift", se_s, 1);
            end
            @(posedge clock); #1;
            budget++;
        end
        start[s] = 1'b0;
        pixel_valid = 1'b0;
        chk("frame_done_seen", dn_s, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_wins(input int i0, input int i1,
                              input int i2, input int i3);
        int ei[4];
        int er[4];
        int ec[4];
        ei[0] = i0; ei[1] = i1; ei[2] = i2; ei[3] = i3;
        er[0] = 0; er[1] = 0; er[2] = 1; er[3] = 1;
        ec[0] = 0; ec[1] = 1; ec[2] = 0; ec[3] = 1;
        chk("window_count", wq_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq_idx.size()) begin
                chk("window_pixel", wq_idx[i], ei[i]);
                chk("window_row", wq_r[i], er[i]);
                chk("window_col", wq_c[i], ec[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 3'b000;
        pixel_valid = 1'b0;
        window_ready = 1'b0;
        sel = 0;
        mw = 4; mh = 4; mk = 3; ms = 1;
        acc_cnt = 0; done_cnt = 0; stall_cnt = 0;
        #3;
        chk_reset_outs("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        pixel_valid = 1'b1;
        window_ready = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("idle_shift", se_s, 0);
            chk("idle_busy", busy_s, 0);
        end
        pixel_valid = 1'b0;

        run_frame(0, 0, 0, 0);
        check_wins(10, 11, 14, 15);
        chk("s1_done_count", done_cnt, 1);
        chk("s1_stalls", stall_cnt, 0);

        run_frame(0, 1, 0, 0);
        check_wins(10, 11, 14, 15);
        chk("bp_done_count", done_cnt, 1);

        run_frame(1, 0, 0, 0);
        check_wins(14, 17, 32, 35);
        chk("s3_done_count", done_cnt, 1);

        run_frame(2, 0, 1, 0);
        check_wins(14, 16, 26, 28);
        chk("s2_done_count", done_cnt, 1);

        run_frame(0, 0, 0, 7);
        chk("abort_done_count", done_cnt, 0);
        run_frame(0, 0, 0, 0);
        check_wins(10, 11, 14, 15);
        chk("rerun_done_count", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequences a K×K convolution over a W×H image streamed in raster order. It accepts pixels over a valid/ready handshake and emits one shift-enable per accepted pixel to the convolver's shift-register line buffer. It tracks the row/column of each accepted pixel and flags, with a handshake, every cycle in which the line-buffer contents form a valid output window. It sits between the pixel source and the shift-register/multiply-accumulate datapath of the convolver.

## Interface
- `image_width`, 8: pixels per row (W), ≥ kernel_size.
- `image_height`, 8: rows per frame (H), ≥ kernel_size.
- `kernel_size`, 3: window edge (K), ≥ 1.
- `stride`, 1: window step in both axes, 1..K.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `start`  in  1  one-cycle pulse; begins a frame when idle.
- `pixel_valid`  in  1  source has a pixel.
- `pixel_ready`  out  1  block accepts a pixel this cycle.
- `shift_en`  out  1  advance the line buffer by one; equals `pixel_valid & pixel_ready`.
- `window_valid`  out  1  line buffer holds a valid window.
- `window_ready`  in  1  datapath consumes the window this cycle.
- `out_row`  out  clog2(H)  output-map row of the current window.
- `out_col`  out  clog2(W)  output-map column of the current window.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, STREAM, WINDOW, DONE.
- IDLE: `pixel_ready`=0, `busy`=0. `start` → STREAM; clear `col`/`row` counters.
- STREAM: `pixel_ready`=1. On accept, col increments; at W-1 it wraps to 0 and row increments.
- An accepted pixel at (r,c) is a window position iff r≥K-1, c≥K-1, (r-K+1)%stride==0 and (c-K+1)%stride==0.
- Window position accepted → WINDOW; latch `out_row`=(r-K+1)/stride, `out_col`=(c-K+1)/stride.
- Last pixel (H-1,W-1) accepted and not a window position → DONE.
- WINDOW: `window_valid`=1. `pixel_ready`=`window_ready`, so a new pixel may be accepted in the same cycle the window is consumed.
- In WINDOW with `window_ready`=1: if the pending window came from the last pixel → DONE. Otherwise any pixel accepted in that cycle is evaluated exactly as in STREAM: a window position stays in WINDOW with new `out_row`/`out_col`; anything else goes to STREAM.
- In WINDOW with `window_ready`=0: `pixel_ready`=0, and `out_row`/`out_col` are held stable.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- `busy`=1 in STREAM and WINDOW.
- `start` is ignored outside IDLE.
- `pixel_valid` is ignored in IDLE and DONE.
- Reset values: state IDLE, counters 0, `window_valid`=0, `out_row`=0, `out_col`=0, `busy`=0, `done`=0, `pixel_ready`=0, `shift_en`=0.
- Reset asserted mid-frame abandons the frame; no `done` is produced.

## Timing
- Registered outputs: `window_valid`, `out_row`, `out_col`, `busy`, `done`. `pixel_ready` and `shift_en` are combinational from state and inputs.
- Pixel accepted at edge N → `shift_en` high in the cycle before edge N, so the line buffer updates at edge N. `window_valid` rises after edge N, aligned with the updated buffer.
- Throughput with `window_ready`=1 and a continuous source: one pixel per cycle, no bubbles.
- `start` at edge S → `busy`=1 and `pixel_ready`=1 after edge S.
- `done` asserts one cycle after the edge at which the final window is consumed, or at which the final non-window pixel is accepted.

## Structure
- Shared package `conv_pkg`: state enum `seq_state_t`, and a width helper function for the counter widths `clog2(W)`/`clog2(H)`.
- One sub-module, `wrap_counter` (parameter max, inputs inc and clear, outputs value and wrap). It is instantiated twice: column, and row chained on the column's wrap.

## Test plan
- W=H=4, K=3, stride=1, continuous pixels, `window_ready`=1 → windows after pixel indices 10, 11, 14, 15 with (`out_row`,`out_col`) = (0,0), (0,1), (1,0), (1,1); no pixel stalls; `done` one cycle after pixel 15's window.
- Same, `window_ready` held 0 for 3 cycles at the first window → `pixel_ready`=0 and `shift_en`=0 for those cycles; `out_row`/`out_col` stable at (0,0); the next pixel is accepted in the cycle `window_ready` returns to 1.
- W=H=6, K=3, stride=3 → exactly 4 windows, at pixels (2,2), (2,5), (5,2), (5,5), with outputs (0,0), (0,1), (1,0), (1,1).
- W=H=6, K=3, stride=2 → 4 windows, on input rows and columns 2 and 4; last pixel (5,5) is not a window → `done` one cycle after it is accepted.
- Reset pulled low after 7 pixels of a 4×4 frame → outputs immediately at reset values; a new `start` runs a full frame yielding 4 windows.
- `start` pulsed while `busy`=1, and `pixel_valid`=1 while idle → no state change, `shift_en` stays 0.
